// File: rtl/spi_slave.sv
// Oversampled byte-wide SPI slave in the i_Clk domain, SPI_MODE 0-3.
// Define SPI_SLAVE_MISO_TRISTATE_EN to float MISO while deselected.
module spi_slave #(
  parameter int SPI_MODE = 0
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_SPI_MISO
);

  localparam logic CPOL = SPI_MODE[1];
  localparam logic CPHA = SPI_MODE[0];

  // [0],[1] synchronize; [2] is the edge-detect history
  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;

  logic [7:0] tx_hold;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic [2:0] bit_cnt;
  logic       miso;

  logic       rise;
  logic       fall;
  logic       lead;
  logic       trail;
  logic       sample_edge;
  logic       shift_edge;
  logic       active;
  logic       cs_fall;
  logic [7:0] hold_next;
  logic [7:0] rx_next;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sclk_q <= {3{CPOL}};
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], i_SPI_Clk};
      cs_q   <= {cs_q[1:0], i_SPI_CS_n};
      mosi_q <= {mosi_q[0], i_SPI_MOSI};
    end
  end

  assign rise        = sclk_q[1] & ~sclk_q[2];
  assign fall        = ~sclk_q[1] & sclk_q[2];
  assign lead        = CPOL ? fall : rise;
  assign trail       = CPOL ? rise : fall;
  assign sample_edge = CPHA ? trail : lead;
  assign shift_edge  = CPHA ? lead : trail;
  assign active      = ~cs_q[1];
  assign cs_fall     = ~cs_q[1] & cs_q[2];

  // A same-cycle strobe wins over the old holding value
  assign hold_next = i_TX_DV ? i_TX_Byte : tx_hold;
  assign rx_next   = {rx_shift[6:0], mosi_q[1]};

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      tx_hold   <= 8'h00;
      tx_shift  <= 8'h00;
      rx_shift  <= 8'h00;
      bit_cnt   <= 3'd0;
      miso      <= 1'b1;
      o_RX_DV   <= 1'b0;
      o_RX_Byte <= 8'h00;
    end else begin
      o_RX_DV <= 1'b0;
      if (i_TX_DV) begin
        tx_hold <= i_TX_Byte;
      end
      if (!active) begin
        bit_cnt  <= 3'd0;
        rx_shift <= 8'h00;
        miso     <= 1'b1;
      end else if (cs_fall) begin
        bit_cnt  <= 3'd0;
        rx_shift <= 8'h00;
        if (CPHA) begin
          tx_shift <= hold_next;
        end else begin
          miso     <= hold_next[7];
          tx_shift <= {hold_next[6:0], 1'b0};
        end
      end else begin
        if (sample_edge) begin
          rx_shift <= rx_next;
          bit_cnt  <= bit_cnt + 3'd1;
          // Full byte: publish it and queue the next TX byte whole
          if (bit_cnt == 3'd7) begin
            o_RX_Byte <= rx_next;
            o_RX_DV   <= 1'b1;
            tx_shift  <= hold_next;
          end
        end
        if (shift_edge) begin
          miso     <= tx_shift[7];
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign o_SPI_MISO = (cs_q[1] || !i_Rst_L) ? 1'bz : miso;
`else
  assign o_SPI_MISO = miso;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: one instance per SPI mode,
// a bit-banged master and a strobe monitor.
module tb_spi_slave;

  localparam int HALF = 8;

  logic       clk;
  logic       rst;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       mosi;
  logic [3:0] sclk;
  logic [3:0] cs_n;
  logic [3:0] dv;
  logic [7:0] rxb [4];
  wire  [3:0] miso;

  int         tests;
  int         failed;
  int         dbl;
  logic [3:0] dv_prev;
  logic [7:0] rxq [$];
  logic [7:0] r0;
  logic [7:0] r1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(.SPI_MODE(g)) u_dut (
      .i_Clk      (clk),
      .i_Rst_L    (rst),
      .i_TX_DV    (tx_dv),
      .i_TX_Byte  (tx_byte),
      .i_SPI_Clk  (sclk[g]),
      .i_SPI_CS_n (cs_n[g]),
      .i_SPI_MOSI (mosi),
      .o_RX_DV    (dv[g]),
      .o_RX_Byte  (rxb[g]),
      .o_SPI_MISO (miso[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    dbl     = 0;
    dv_prev = 4'b0;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (dv[k] === 1'b1) begin
        if (dv_prev[k]) dbl++;
        rxq.push_back(rxb[k]);
      end
    end
    dv_prev = dv;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_tx(input logic [7:0] b);
    tx_dv   = 1'b1;
    tx_byte = b;
    tick(1);
    tx_dv   = 1'b0;
    tick(2);
  endtask

  task automatic xfer(input int m, input logic [7:0] tx,
                      input int nbits, output logic [7:0] rx);
    logic pol;
    logic pha;
    pol = m[1];
    pha = m[0];
    rx  = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!pha) begin
        mosi = tx[i];
        tick(HALF);
        sclk[m] = ~pol;
        rx[i] = miso[m];
        tick(HALF);
        sclk[m] = pol;
      end else begin
        sclk[m] = ~pol;
        mosi = tx[i];
        tick(HALF);
        rx[i] = miso[m];
        sclk[m] = pol;
        tick(HALF);
      end
    end
  endtask

  task automatic cs_low(input int m);
    cs_n[m] = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_high(input int m);
    tick(HALF);
    cs_n[m] = 1'b1;
    tick(HALF);
  endtask

  initial begin
    tests   = 0;
    failed  = 0;
    rst     = 1'b0;
    tx_dv   = 1'b0;
    tx_byte = 8'h00;
    mosi    = 1'b0;
    sclk    = 4'b1100;
    cs_n    = 4'b1111;

    tick(3);
    check("rst_dv", {7'b0, dv[0]}, 8'h00);
    check("rst_byte", rxb[0], 8'h00);
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    check("rst_miso", {7'b0, miso[0]}, {7'b0, 1'bz});
`else
    check("rst_miso", {7'b0, miso[0]}, 8'h01);
`endif
    rst = 1'b1;
    tick(4);

    rxq.delete();
    cs_low(0);
    xfer(0, 8'h89, 8, r0);
    xfer(0, 8'h81, 8, r1);
    cs_high(0);
    check("m0_rx_count", 8'(rxq.size()), 8'd2);
    if (rxq.size() == 2) begin
      check("m0_rx_first", rxq[0], 8'h89);
      check("m0_rx_second", rxq[1], 8'h81);
    end
    check("m0_rx_hold", rxb[0], 8'h81);

    load_tx(8'hA5);
    rxq.delete();
    cs_low(0);
    xfer(0, 8'h12, 8, r0);
    xfer(0, 8'h34, 8, r1);
    cs_high(0);
    check("tx_first", r0, 8'hA5);
    check("tx_repeat", r1, 8'hA5);
    check("tx_rx_count", 8'(rxq.size()), 8'd2);
    if (rxq.size() == 2) check("tx_rx_last", rxq[1], 8'h34);

    rxq.delete();
    cs_low(0);
    xfer(0, 8'hFE, 5, r0);
    cs_high(0);
    check("abort_no_dv", 8'(rxq.size()), 8'd0);
    check("abort_hold", rxb[0], 8'h34);
    cs_low(0);
    xfer(0, 8'hBA, 8, r0);
    cs_high(0);
    check("abort_count", 8'(rxq.size()), 8'd1);
    check("abort_byte", rxb[0], 8'hBA);

    for (int m = 1; m < 4; m++) begin
      load_tx(8'hC3);
      rxq.delete();
      cs_low(m);
      xfer(m, 8'h3C, 8, r0);
      cs_high(m);
      check($sformatf("mode%0d_count", m), 8'(rxq.size()), 8'd1);
      check($sformatf("mode%0d_rx", m), rxb[m], 8'h3C);
      check($sformatf("mode%0d_tx", m), r0, 8'hC3);
    end

    load_tx(8'h11);
    rxq.delete();
    cs_n[0] = 1'b0;
    tick(2);
    tx_dv   = 1'b1;
    tx_byte = 8'h5A;
    tick(1);
    tx_dv   = 1'b0;
    tick(HALF - 3);
    xfer(0, 8'h77, 8, r0);
    cs_high(0);
    check("collision_tx", r0, 8'h5A);
    check("collision_rx", rxb[0], 8'h77);

    check("dv_single_cycle", 8'(dbl), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
